// File: rtl/atm_pkg.sv
// atm_pkg: constants shared by the ATM session controller and its account bank.
//   - FSM state codes. These are also the values driven on the `state` debug port.
//   - Operation codes for the opCode input.
//   - Default PIN base and the default balance width.
package atm_pkg;

  localparam int BAL_W_DEF = 16;

  // Account k has the default PIN (PIN_BASE + k) mod 16.
  localparam logic [3:0] PIN_BASE = 4'hA;

  localparam logic [1:0] OP_BAL   = 2'b00;
  localparam logic [1:0] OP_DEP   = 2'b01;
  localparam logic [1:0] OP_WDR   = 2'b10;
  localparam logic [1:0] OP_EJECT = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_PIN = 3'd1;
  localparam logic [2:0] ST_MENU     = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_RESULT   = 3'd4;
  localparam logic [2:0] ST_EJECT    = 3'd5;
  localparam logic [2:0] ST_LOCKED   = 3'd6;

  // A session counts as authenticated from PIN acceptance until it leaves RESULT.
  function automatic logic is_authenticated(input logic [2:0] st);
    return (st == ST_MENU) || (st == ST_EXEC) || (st == ST_RESULT);
  endfunction

endpackage

// File: rtl/atm_account_bank.sv
// atm_account_bank: storage for the balance and PIN of each account.
// Ports:
//   clk, reset            rising-edge clock; synchronous active-low reset
//   rd_addr_i             account to read
//   rd_bal_o, rd_pin_o    combinational read of that account's balance and PIN
//   wr_en_i, wr_addr_i    balance write strobe and target account
//   wr_data_i             new balance
// On reset, every balance loads INIT_BAL and every PIN loads its default value.
// The PINs have no write port, so they keep their reset values.
module atm_account_bank
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 4,
  parameter int BAL_W        = BAL_W_DEF,
  parameter int INIT_BAL     = 1000,
  localparam int AW          = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [BAL_W-1:0] rd_bal_o,
  output logic [3:0]       rd_pin_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [BAL_W-1:0] wr_data_i
);

  logic [BAL_W-1:0] bal_q [NUM_ACCOUNTS];
  logic [3:0]       pin_q [NUM_ACCOUNTS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ACCOUNTS; k++) begin
        bal_q[k] <= BAL_W'(INIT_BAL);
        pin_q[k] <= PIN_BASE + 4'(k);
      end
    end else if (wr_en_i) begin
      bal_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_bal_o = bal_q[rd_addr_i];
  assign rd_pin_o = pin_q[rd_addr_i];

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: runs one ATM session at a time. The sequence is card insert,
// PIN check with attempt lockout, one balance/deposit/withdraw operation at a time,
// inactivity timeout, then card eject.
// Ports:
//   clk, reset              rising-edge clock; synchronous active-low reset
//   cardIn                  level: a card is in the slot
//   accountId               account on the card; captured when a session starts
//   password, pinValid      keypad PIN and its 1-cycle strobe
//   opCode, amount, opValid requested operation, its amount, and its 1-cycle strobe
//   Another_Operation       in RESULT: go back to MENU
//   ejectCard               in MENU or RESULT: end the session
//   correctPassword         high while the session is authenticated
//   Balance_Shown, Deposited_Successfully, Withdrawed_Successfully, insufficientFunds
//                           1-cycle result pulses; they appear on the first RESULT cycle
//   balanceOut              post-operation balance while in RESULT, otherwise 0
//   cardRetained            high in LOCKED
//   ATM_Usage_Finished      1-cycle pulse on entry to EJECT
//   state                   current FSM state (debug)
// Strobe semantics: pinValid, opValid, Another_Operation and ejectCard have no
// ready signal. Each is a 1-cycle request. It is acted on only in a state that
// accepts it, and it is dropped in every other state.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 4,
  parameter int BAL_W        = BAL_W_DEF,
  parameter int INIT_BAL     = 1000,
  parameter int MAX_ATTEMPTS = 3,
  parameter int TIMEOUT_CYC  = 255,
  localparam int AW          = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cardIn,
  input  logic [AW-1:0]    accountId,
  input  logic [3:0]       password,
  input  logic             pinValid,
  input  logic [1:0]       opCode,
  input  logic             opValid,
  input  logic [BAL_W-1:0] amount,
  input  logic             Another_Operation,
  input  logic             ejectCard,
  output logic             correctPassword,
  output logic             Balance_Shown,
  output logic             Deposited_Successfully,
  output logic             Withdrawed_Successfully,
  output logic             insufficientFunds,
  output logic [BAL_W-1:0] balanceOut,
  output logic             cardRetained,
  output logic             ATM_Usage_Finished,
  output logic [2:0]       state
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    acct_q, acct_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       op_q, op_d;
  logic [BAL_W-1:0] amt_q, amt_d;

  logic             cp_q, bs_q, dep_q, wdr_q, nof_q, ret_q, fin_q;
  logic [BAL_W-1:0] bo_q;

  logic [BAL_W-1:0] rd_bal, new_bal;
  logic [3:0]       rd_pin;
  logic [BAL_W:0]   dep_sum;
  logic             bal_shown, dep_ok, wdr_ok, no_funds, wr_en;
  logic             timed, input_seen, to_hit;

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS),
    .BAL_W       (BAL_W),
    .INIT_BAL    (INIT_BAL)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .rd_addr_i(acct_q),
    .rd_bal_o (rd_bal),
    .rd_pin_o (rd_pin),
    .wr_en_i  (wr_en),
    .wr_addr_i(acct_q),
    .wr_data_i(new_bal)
  );

  // Operation datapath. A deposit saturates at the largest balance the width can hold.
  // A withdraw that exceeds the balance leaves the balance unchanged.
  assign dep_sum = {1'b0, rd_bal} + {1'b0, amt_q};

  always_comb begin
    new_bal   = rd_bal;
    bal_shown = 1'b0;
    dep_ok    = 1'b0;
    wdr_ok    = 1'b0;
    no_funds  = 1'b0;
    case (op_q)
      OP_DEP: begin
        new_bal = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
        dep_ok  = 1'b1;
      end
      OP_WDR: begin
        if (amt_q <= rd_bal) begin
          new_bal = rd_bal - amt_q;
          wdr_ok  = 1'b1;
        end else begin
          no_funds = 1'b1;
        end
      end
      OP_BAL:  bal_shown = 1'b1;
      default: bal_shown = 1'b1;
    endcase
  end

  assign wr_en  = (state_q == ST_EXEC) && (dep_ok || wdr_ok);
  assign to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));

  // Next-state logic. In every state that waits on a person, cardIn=0 takes priority.
  // Such states time out on the cycle the idle count would reach TIMEOUT_CYC.
  always_comb begin
    state_d    = state_q;
    acct_d     = acct_q;
    att_d      = att_q;
    op_d       = op_q;
    amt_d      = amt_q;
    timed      = 1'b0;
    input_seen = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cardIn) begin
          acct_d  = accountId;
          att_d   = '0;
          state_d = ST_WAIT_PIN;
        end
      end
      ST_WAIT_PIN: begin
        timed = 1'b1;
        if (!cardIn) begin
          state_d = ST_IDLE;
        end else if (pinValid) begin
          input_seen = 1'b1;
          if (password == rd_pin) begin
            state_d = ST_MENU;
          end else begin
            att_d = att_q + ATT_W'(1);
            if (att_d == ATT_W'(MAX_ATTEMPTS)) state_d = ST_LOCKED;
          end
        end else if (to_hit) begin
          state_d = ST_EJECT;
        end
      end
      ST_MENU: begin
        timed = 1'b1;
        if (!cardIn) begin
          state_d = ST_IDLE;
        end else if (ejectCard || (opValid && opCode == OP_EJECT)) begin
          input_seen = 1'b1;
          state_d    = ST_EJECT;
        end else if (opValid) begin
          input_seen = 1'b1;
          op_d       = opCode;
          amt_d      = amount;
          state_d    = ST_EXEC;
        end else if (to_hit) begin
          state_d = ST_EJECT;
        end
      end
      // The update always completes. If the card has been pulled, skip RESULT.
      ST_EXEC: state_d = cardIn ? ST_RESULT : ST_IDLE;
      ST_RESULT: begin
        timed = 1'b1;
        if (!cardIn) begin
          state_d = ST_IDLE;
        end else if (ejectCard) begin
          input_seen = 1'b1;
          state_d    = ST_EJECT;
        end else if (Another_Operation) begin
          input_seen = 1'b1;
          state_d    = ST_MENU;
        end else if (to_hit) begin
          state_d = ST_EJECT;
        end
      end
      ST_EJECT: if (!cardIn) state_d = ST_IDLE;
      ST_LOCKED: state_d = ST_LOCKED;
      default: state_d = ST_IDLE;
    endcase
    to_d = (state_d != state_q || input_seen || !timed) ? '0 : to_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acct_q  <= '0;
      att_q   <= '0;
      to_q    <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      cp_q    <= 1'b0;
      bs_q    <= 1'b0;
      dep_q   <= 1'b0;
      wdr_q   <= 1'b0;
      nof_q   <= 1'b0;
      bo_q    <= '0;
      ret_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acct_q  <= acct_d;
      att_q   <= att_d;
      to_q    <= to_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      cp_q    <= is_authenticated(state_d);
      bs_q    <= (state_q == ST_EXEC) && bal_shown;
      dep_q   <= (state_q == ST_EXEC) && dep_ok;
      wdr_q   <= (state_q == ST_EXEC) && wdr_ok;
      nof_q   <= (state_q == ST_EXEC) && no_funds;
      // Capture the balance on the way into RESULT and hold it while there.
      bo_q    <= (state_d != ST_RESULT) ? '0 :
                 (state_q == ST_EXEC)   ? new_bal : bo_q;
      ret_q   <= (state_d == ST_LOCKED);
      fin_q   <= (state_d == ST_EJECT) && (state_q != ST_EJECT);
    end
  end

  assign correctPassword         = cp_q;
  assign Balance_Shown           = bs_q;
  assign Deposited_Successfully  = dep_q;
  assign Withdrawed_Successfully = wdr_q;
  assign insufficientFunds       = nof_q;
  assign balanceOut              = bo_q;
  assign cardRetained            = ret_q;
  assign ATM_Usage_Finished      = fin_q;
  assign state                   = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed scenarios, then randomized traffic.
// A session-level model in the bench predicts every output on every cycle.
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int BAL_W    = 16;
  localparam int NACC     = 4;
  localparam int INIT_BAL = 1000;
  localparam int MAX_ATT  = 3;
  localparam int TIMEOUT  = 255;
  localparam int MAX_BAL  = (1 << BAL_W) - 1;
  localparam int VW       = 26;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cardIn = 1'b0;
  logic [1:0]       accountId = '0;
  logic [3:0]       password = '0;
  logic             pinValid = 1'b0;
  logic [1:0]       opCode = '0;
  logic             opValid = 1'b0;
  logic [BAL_W-1:0] amount = '0;
  logic             Another_Operation = 1'b0;
  logic             ejectCard = 1'b0;
  logic             correctPassword, Balance_Shown, Deposited_Successfully;
  logic             Withdrawed_Successfully, insufficientFunds, cardRetained;
  logic             ATM_Usage_Finished;
  logic [BAL_W-1:0] balanceOut;
  logic [2:0]       state;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .NUM_ACCOUNTS(NACC), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL),
    .MAX_ATTEMPTS(MAX_ATT), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cardIn(cardIn), .accountId(accountId),
    .password(password), .pinValid(pinValid), .opCode(opCode), .opValid(opValid),
    .amount(amount), .Another_Operation(Another_Operation), .ejectCard(ejectCard),
    .correctPassword(correctPassword), .Balance_Shown(Balance_Shown),
    .Deposited_Successfully(Deposited_Successfully),
    .Withdrawed_Successfully(Withdrawed_Successfully),
    .insufficientFunds(insufficientFunds), .balanceOut(balanceOut),
    .cardRetained(cardRetained), .ATM_Usage_Finished(ATM_Usage_Finished),
    .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural session model ----------------
  typedef enum int {M_IDLE, M_PIN, M_MENU, M_EXEC, M_RESULT, M_EJECT, M_LOCKED} mode_t;

  mode_t m_mode = M_IDLE;
  int    m_bal[NACC];
  int    m_acct = 0, m_att = 0, m_idle = 0, m_op = 0, m_amt = 0, m_bo = 0;
  logic [VW-1:0] exp_q[$];

  function automatic logic [2:0] code_of(input mode_t m);
    case (m)
      M_IDLE:   return ST_IDLE;
      M_PIN:    return ST_WAIT_PIN;
      M_MENU:   return ST_MENU;
      M_EXEC:   return ST_EXEC;
      M_RESULT: return ST_RESULT;
      M_EJECT:  return ST_EJECT;
      default:  return ST_LOCKED;
    endcase
  endfunction

  function automatic logic [VW-1:0] pack(input logic cp, bs, dp, wd, ins,
                                         input logic [BAL_W-1:0] bo,
                                         input logic ret, fin, input logic [2:0] st);
    return {cp, bs, dp, wd, ins, bo, ret, fin, st};
  endfunction

  always @(posedge clk) begin : model
    mode_t nm;
    logic  bs, dp, wd, ins, seen, timed;
    int    b;
    bs = 0; dp = 0; wd = 0; ins = 0; seen = 0; timed = 0;
    if (!reset) begin
      m_mode = M_IDLE;
      for (int k = 0; k < NACC; k++) m_bal[k] = INIT_BAL;
      m_att = 0; m_idle = 0; m_bo = 0;
      exp_q.push_back('0);
    end else begin
      nm = m_mode;
      case (m_mode)
        M_IDLE: if (cardIn) begin m_acct = int'(accountId); m_att = 0; nm = M_PIN; end
        M_PIN: begin
          timed = 1;
          if (!cardIn) nm = M_IDLE;
          else if (pinValid) begin
            seen = 1;
            if (int'(password) == (10 + m_acct) % 16) nm = M_MENU;
            else begin
              m_att = m_att + 1;
              if (m_att >= MAX_ATT) nm = M_LOCKED;
            end
          end else if (m_idle + 1 >= TIMEOUT) nm = M_EJECT;
        end
        M_MENU: begin
          timed = 1;
          if (!cardIn) nm = M_IDLE;
          else if (ejectCard || (opValid && opCode == 2'd3)) begin seen = 1; nm = M_EJECT; end
          else if (opValid) begin
            seen = 1; m_op = int'(opCode); m_amt = int'(amount); nm = M_EXEC;
          end else if (m_idle + 1 >= TIMEOUT) nm = M_EJECT;
        end
        M_EXEC: begin
          b = m_bal[m_acct];
          if (m_op == 1) begin
            m_bal[m_acct] = (b + m_amt > MAX_BAL) ? MAX_BAL : b + m_amt; dp = 1;
          end else if (m_op == 2) begin
            if (m_amt <= b) begin m_bal[m_acct] = b - m_amt; wd = 1; end
            else ins = 1;
          end else bs = 1;
          nm = cardIn ? M_RESULT : M_IDLE;
          m_bo = m_bal[m_acct];
        end
        M_RESULT: begin
          timed = 1;
          if (!cardIn) nm = M_IDLE;
          else if (ejectCard) begin seen = 1; nm = M_EJECT; end
          else if (Another_Operation) begin seen = 1; nm = M_MENU; end
          else if (m_idle + 1 >= TIMEOUT) nm = M_EJECT;
        end
        M_EJECT: if (!cardIn) nm = M_IDLE;
        default: nm = M_LOCKED;
      endcase
      if (nm != M_RESULT) m_bo = 0;
      m_idle = (nm == m_mode && !seen && timed) ? m_idle + 1 : 0;
      exp_q.push_back(pack(nm == M_MENU || nm == M_EXEC || nm == M_RESULT,
                           bs, dp, wd, ins, BAL_W'(m_bo), nm == M_LOCKED,
                           nm == M_EJECT && m_mode != M_EJECT, code_of(nm)));
      m_mode = nm;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(posedge clk) begin : compare
    logic [VW-1:0] e, a;
    #1;
    a = pack(correctPassword, Balance_Shown, Deposited_Successfully,
             Withdrawed_Successfully, insufficientFunds, balanceOut,
             cardRetained, ATM_Usage_Finished, state);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t: no expected entry, got %h", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  // ---------------- literal checks and driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    pinValid = 0; opValid = 0; Another_Operation = 0; ejectCard = 0;
  endtask

  task automatic enter_pin(input logic [3:0] p);
    password = p; pinValid = 1; step();
  endtask

  task automatic login(input int acct);
    cardIn = 1; accountId = 2'(acct); step();
    enter_pin(4'(10 + acct));
  endtask

  // Returns on the first RESULT cycle.
  task automatic do_op(input logic [1:0] op, input int amt);
    opCode = op; amount = BAL_W'(amt); opValid = 1; step(); step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_outputs", 32'({correctPassword, Balance_Shown, Deposited_Successfully,
          Withdrawed_Successfully, insufficientFunds, balanceOut, cardRetained,
          ATM_Usage_Finished}), 0);
    reset = 1;

    // Account 0: withdraw 300, then eject.
    login(0);
    check("s1_auth", 32'(correctPassword), 1);
    do_op(OP_WDR, 300);
    check("s1_wdr_pulse", 32'(Withdrawed_Successfully), 1);
    check("s1_bal_out", 32'(balanceOut), 700);
    check("s1_model_bal", 32'(m_bal[0]), 700);
    ejectCard = 1; step();
    check("s1_finished", 32'(ATM_Usage_Finished), 1);
    check("s1_cp_low", 32'(correctPassword), 0);
    cardIn = 0; step();
    check("s1_idle", 32'(state), 32'(ST_IDLE));

    // Account 1: three wrong PINs lock the card. Only reset clears LOCKED.
    cardIn = 1; accountId = 2'd1; step();
    enter_pin(4'h0); enter_pin(4'h1);
    check("s2_cp_low", 32'(correctPassword), 0);
    enter_pin(4'h2);
    check("s2_locked", 32'(state), 32'(ST_LOCKED));
    check("s2_retained", 32'(cardRetained), 1);
    check("s2_cp_still_low", 32'(correctPassword), 0);
    cardIn = 0; reset = 0; step(); reset = 1;
    check("s2_reset_idle", 32'(state), 32'(ST_IDLE));
    check("s2_released", 32'(cardRetained), 0);

    // Account 2: insufficient funds, then a saturating deposit, then both RESULT strobes at once.
    login(2);
    do_op(OP_WDR, 1001);
    check("s3_nofunds", 32'(insufficientFunds), 1);
    check("s3_bal_out", 32'(balanceOut), 1000);
    Another_Operation = 1; step();
    check("s3_menu", 32'(state), 32'(ST_MENU));
    do_op(OP_DEP, 65000);
    check("s3_dep_pulse", 32'(Deposited_Successfully), 1);
    check("s3_saturate", 32'(balanceOut), 65535);
    Another_Operation = 1; ejectCard = 1; step();
    check("s3_eject_wins", 32'(state), 32'(ST_EJECT));
    check("s3_finished", 32'(ATM_Usage_Finished), 1);
    cardIn = 0; step();

    // Account 3: an idle MENU forces eject after TIMEOUT cycles.
    login(3);
    n = 0;
    while (state !== ST_EJECT && n < 400) begin step(); n++; end
    check("s4_timeout_cycles", 32'(n), 255);
    check("s4_finished", 32'(ATM_Usage_Finished), 1);
    cardIn = 0; step();

    // Account 0: deposit 50, pull the card in MENU, reinsert, then query.
    login(0);
    do_op(OP_DEP, 50);
    check("s5_dep_bal", 32'(balanceOut), 1050);
    Another_Operation = 1; step();
    cardIn = 0; step();
    check("s5_pull_idle", 32'(state), 32'(ST_IDLE));
    check("s5_no_finish", 32'(ATM_Usage_Finished), 0);
    login(0);
    do_op(OP_BAL, 0);
    check("s5_shown", 32'(Balance_Shown), 1);
    check("s5_bal", 32'(balanceOut), 1050);

    // Reset during EXEC of a deposit restores every balance.
    Another_Operation = 1; step();
    opCode = OP_DEP; amount = 16'd100; opValid = 1; step();
    check("s6_in_exec", 32'(state), 32'(ST_EXEC));
    reset = 0; step(); reset = 1;
    check("s6_outputs_zero", 32'({correctPassword, Balance_Shown, Deposited_Successfully,
          balanceOut, ATM_Usage_Finished, state}), 0);
    check("s6_model_bal", 32'(m_bal[0]), 1000);
    login(0);
    do_op(OP_BAL, 0);
    check("s6_bal_restored", 32'(balanceOut), 1000);
    Another_Operation = 1; step();
    do_op(OP_WDR, 0);
    check("s6_wdr_zero_ok", 32'(Withdrawed_Successfully), 1);
    check("s6_wdr_zero_bal", 32'(balanceOut), 1000);
    cardIn = 0; step();

    // Random traffic; the per-cycle compare checks every cycle.
    repeat (2500) begin
      reset  = ($urandom_range(0, 399) != 0);
      cardIn = cardIn ? ($urandom_range(0, 79) != 0) : ($urandom_range(0, 3) == 0);
      accountId = 2'($urandom_range(0, 3));
      pinValid  = ($urandom_range(0, 5) == 0);
      password  = $urandom_range(0, 1) ? 4'(10 + m_acct) : 4'($urandom_range(0, 15));
      opValid   = ($urandom_range(0, 4) == 0);
      opCode    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       amount = '0;
        1:       amount = BAL_W'($urandom_range(1, 500));
        2:       amount = BAL_W'($urandom_range(60000, 65535));
        default: amount = BAL_W'($urandom_range(0, 65535));
      endcase
      Another_Operation = ($urandom_range(0, 4) == 0);
      ejectCard         = ($urandom_range(0, 24) == 0);
      @(negedge clk);
    end
    reset = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
